// File: rtl/sqrt_reconstruct.sv
// sqrt_reconstruct: rebuilds radical = q*q + remainder from a square-root
// result pair using a one-bit-per-cycle shift-add squarer. Flags sums that
// do not fit in the radical width and pairs with remainder > 2*q, which no
// valid square-root output can produce.
module sqrt_reconstruct #(
  parameter int Q_WIDTH = 8,
  parameter int R_WIDTH = 9,
  parameter int WIDTH   = 16
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] q,
  input  logic [R_WIDTH-1:0] remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   radical,
  output logic               overflow,
  output logic               noncanonical
);

  localparam int ACC_W = 2 * Q_WIDTH;
  localparam int SUM_W = ((ACC_W > R_WIDTH) ? ACC_W : R_WIDTH) + 1;
  // Wide enough to hold the full sum and at least one bit above the radical.
  localparam int EXT_W = (SUM_W > WIDTH) ? SUM_W : WIDTH + 1;
  localparam int CMP_W = ((Q_WIDTH + 1) > R_WIDTH) ? (Q_WIDTH + 1) : R_WIDTH;
  localparam int CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [Q_WIDTH-1:0] q_reg;
  logic [R_WIDTH-1:0] r_reg;

  logic [ACC_W-1:0]   partial;
  logic [EXT_W-1:0]   sum_ext;
  logic [WIDTH-1:0]   radical_next;
  logic               overflow_next;
  logic               noncanonical_next;

  // Squarer step term and final-sum arithmetic, all at full width.
  always_comb begin
    partial           = q_reg[cnt] ? ACC_W'(q_reg) : '0;
    sum_ext           = EXT_W'(acc) + EXT_W'(r_reg);
    radical_next      = sum_ext[WIDTH-1:0];
    overflow_next     = |sum_ext[EXT_W-1:WIDTH];
    noncanonical_next = CMP_W'(r_reg) > (CMP_W'(q_reg) << 1);
  end

  // State register.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; nothing advances while ena is low.
  always_comb begin
    state_next = state;
    if (ena) begin
      case (state)
        IDLE:    if (in_valid) state_next = MUL;
        MUL:     if (cnt == '0) state_next = ADD;
        ADD:     state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand capture, MSB-first shift-add squaring, final sum.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc          <= '0;
      cnt          <= '0;
      q_reg        <= '0;
      r_reg        <= '0;
      radical      <= '0;
      overflow     <= 1'b0;
      noncanonical <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg <= q;
            r_reg <= remainder;
            acc   <= '0;
            cnt   <= CNT_W'(Q_WIDTH - 1);
          end
        end
        MUL: begin
          acc <= (acc << 1) + partial;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ADD: begin
          radical      <= radical_next;
          overflow     <= overflow_next;
          noncanonical <= noncanonical_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// tb_sqrt_reconstruct: directed and randomized checks of sqrt_reconstruct
// against a transaction-level model of q*q + remainder and its timing.
module tb_sqrt_reconstruct;

  localparam int QW  = 8;
  localparam int RW  = 9;
  localparam int W   = 16;
  localparam int LAT = QW + 1;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          ena = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [QW-1:0] q = '0;
  logic [RW-1:0] remainder = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  radical;
  logic          overflow;
  logic          noncanonical;

  int n_checks = 0;
  int n_passed = 0;

  // Model state: one pending transaction, its enabled-cycle age, and the
  // result currently/previously presented on the output registers.
  bit pend;
  int steps;
  int cur_rad, cur_ov, cur_nc;
  int prev_rad, prev_ov, prev_nc;

  sqrt_reconstruct #(.Q_WIDTH(QW), .R_WIDTH(RW), .WIDTH(W)) dut (
    .clk(clk),
    .aclr(aclr),
    .ena(ena),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .q(q),
    .remainder(remainder),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .radical(radical),
    .overflow(overflow),
    .noncanonical(noncanonical)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Transaction model: acceptance, aging by enabled edges, output handshake.
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pend = 0; steps = 0;
      cur_rad = 0; cur_ov = 0; cur_nc = 0;
      prev_rad = 0; prev_ov = 0; prev_nc = 0;
    end else if (ena) begin
      if (pend) begin
        if (steps >= LAT && out_ready) pend = 0;
        else if (steps < LAT) steps++;
      end else if (in_valid) begin
        int s;
        s = int'(q) * int'(q) + int'(remainder);
        prev_rad = cur_rad; prev_ov = cur_ov; prev_nc = cur_nc;
        cur_rad = s % (1 << W);
        cur_ov  = (s >= (1 << W)) ? 1 : 0;
        cur_nc  = (int'(remainder) > 2 * int'(q)) ? 1 : 0;
        pend = 1; steps = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!aclr) begin
      check_output("in_ready", in_ready, !pend);
      check_output("out_valid", out_valid, (pend && steps >= LAT));
      if (pend && steps < LAT) begin
        check_output("radical held", radical, prev_rad);
        check_output("overflow held", overflow, prev_ov);
        check_output("noncanonical held", noncanonical, prev_nc);
      end else begin
        check_output("radical", radical, cur_rad);
        check_output("overflow", overflow, cur_ov);
        check_output("noncanonical", noncanonical, cur_nc);
      end
    end
  end

  // Offer one pair, optionally stall ena, and wait (bounded) for out_valid.
  task automatic apply_stimulus(input int qv, input int rv, input int stall_at,
                                input int stall_len, input int exp_rad,
                                input int exp_ov, input int exp_nc, input int exp_lat);
    int k;
    int lat;
    @(negedge clk);
    ena = 1'b1;
    check_output("dir in_ready before", in_ready, 1);
    q = QW'(qv);
    remainder = RW'(rv);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    lat = -1;
    while (lat < 0 && k < 40) begin
      if (out_valid) begin
        lat = k;
      end else begin
        ena = !(k >= stall_at && k < stall_at + stall_len);
        q = QW'($urandom);
        remainder = RW'($urandom);
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
    ena = 1'b1;
    check_output("dir latency", lat, exp_lat);
    check_output("dir radical", radical, exp_rad);
    check_output("dir overflow", overflow, exp_ov);
    check_output("dir noncanonical", noncanonical, exp_nc);
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_output("release out_valid", out_valid, 0);
    check_output("release in_ready", in_ready, 1);
  endtask

  initial begin
    int x, qq;
    #1;
    check_output("reset in_ready", in_ready, 1);
    check_output("reset out_valid", out_valid, 0);
    check_output("reset radical", radical, 0);
    check_output("reset overflow", overflow, 0);
    check_output("reset noncanonical", noncanonical, 0);
    repeat (2) @(negedge clk);
    aclr = 1'b0;

    apply_stimulus(255, 0, -10, 0, 65025, 0, 0, 9);
    release_output();
    apply_stimulus(255, 510, -10, 0, 65535, 0, 0, 9);
    release_output();
    apply_stimulus(255, 511, -10, 0, 0, 1, 1, 9);
    release_output();
    apply_stimulus(0, 0, -10, 0, 0, 0, 0, 9);
    release_output();
    apply_stimulus(3, 7, -10, 0, 16, 0, 1, 9);
    release_output();

    // Backpressure: result and handshake outputs hold for 20 cycles.
    apply_stimulus(100, 37, -10, 0, 10037, 0, 0, 9);
    for (int i = 0; i < 20; i++) begin
      check_output("bp out_valid", out_valid, 1);
      check_output("bp radical", radical, 10037);
      check_output("bp in_ready", in_ready, 0);
      @(negedge clk);
    end
    release_output();

    // Enable stall of 3 cycles in the middle of the squaring.
    apply_stimulus(201, 44, 3, 3, 40445, 0, 0, 12);
    release_output();

    // Asynchronous clear at MUL step 4 drops the transaction.
    @(negedge clk);
    q = 8'd200;
    remainder = 9'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 aclr = 1'b1;
    #1;
    check_output("aclr radical", radical, 0);
    check_output("aclr overflow", overflow, 0);
    check_output("aclr noncanonical", noncanonical, 0);
    check_output("aclr in_ready", in_ready, 1);
    check_output("aclr out_valid", out_valid, 0);
    @(negedge clk);
    aclr = 1'b0;
    apply_stimulus(16, 5, -10, 0, 261, 0, 0, 9);
    release_output();

    // Round trip through an integer square root: identity, no flags.
    for (int i = 0; i < 30; i++) begin
      x = (i == 0) ? 65535 : int'($urandom_range(65535, 0));
      qq = isqrt(x);
      apply_stimulus(qq, x - qq * qq, -10, 0, x, 0, 0, 9);
      release_output();
    end

    // Free-running random traffic, ena and backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ena = ($urandom_range(3, 0) != 0);
      in_valid = $urandom_range(1, 0);
      out_ready = ($urandom_range(2, 0) != 0);
      q = QW'($urandom);
      remainder = ($urandom_range(1, 0) != 0) ? RW'($urandom) : RW'($urandom_range(2 * int'(q), 0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    ena = 1'b1;
    out_ready = 1'b1;
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
